// File: rtl/regression_error_calc_pkg.sv
// Shared definitions for the regression residual block: FSM state encodings,
// default datapath sizes and the fixed-point multiply/rescale helpers.
package regression_error_calc_pkg;

    localparam int unsigned WORD_LEN_DEF     = 20;
    localparam int unsigned FRAC_BITS_DEF    = 10;
    localparam int unsigned SAMPLE_COUNT_DEF = 150;
    localparam int unsigned IDX_LEN_DEF      = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Full signed product; operands are sign-extended to 32 bits by the caller.
    function automatic logic signed [63:0] fx_mul(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Drops the fractional bits of a product; caller truncates to its word width.
    function automatic logic [31:0] fx_rescale(input logic [63:0] prod,
                                               input int unsigned frac);
        return 32'(prod >> frac);
    endfunction

endpackage

// File: rtl/regression_predict_pipe.sv
// Two-stage prediction pipeline: S1 registers b1*x, S2 forms y_hat = b0 + b1*x
// and err = y - y_hat. Both stages advance only while en is high.
// Build option REGRESSION_ERR_SAT_EN: saturating add/sub plus sticky sat_flag.
module regression_predict_pipe
    import regression_error_calc_pkg::*;
#(
    parameter int unsigned WORD_LEN  = WORD_LEN_DEF,
    parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
    parameter int unsigned IDX_LEN   = IDX_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_fire,
    input  logic [WORD_LEN-1:0] b0,
    input  logic [WORD_LEN-1:0] b1,
    input  logic [WORD_LEN-1:0] x,
    input  logic [WORD_LEN-1:0] y,
    input  logic [IDX_LEN-1:0]  idx_in,
`ifdef REGRESSION_ERR_SAT_EN
    input  logic                clr_sat,
    output logic                sat_flag,
`endif
    output logic                out_valid,
    output logic [WORD_LEN-1:0] y_hat,
    output logic [WORD_LEN-1:0] err,
    output logic [IDX_LEN-1:0]  idx
);

    logic                  v1_q, v2_q;
    logic [2*WORD_LEN-1:0] prod_q, prod_d;
    logic [WORD_LEN-1:0]   y1_q, y_hat_q, err_q, y_hat_d, err_d, scaled_w;
    logic [IDX_LEN-1:0]    idx1_q, idx2_q;

`ifdef REGRESSION_ERR_SAT_EN
    localparam logic [WORD_LEN-1:0] MAX_VAL = {1'b0, {(WORD_LEN-1){1'b1}}};
    localparam logic [WORD_LEN-1:0] MIN_VAL = {1'b1, {(WORD_LEN-1){1'b0}}};
    logic [WORD_LEN:0] sum_ext, diff_ext;
    logic              sat_add, sat_sub, sat_q;
`endif

    // S1 product and S2 add/subtract
    always_comb begin
        prod_d   = (2*WORD_LEN)'(fx_mul(32'($signed(b1)), 32'($signed(x))));
        scaled_w = WORD_LEN'(fx_rescale(64'(prod_q), FRAC_BITS));
`ifdef REGRESSION_ERR_SAT_EN
        // Extra sign bit exposes overflow: top two bits disagree
        sum_ext  = {b0[WORD_LEN-1], b0} + {scaled_w[WORD_LEN-1], scaled_w};
        sat_add  = sum_ext[WORD_LEN] ^ sum_ext[WORD_LEN-1];
        y_hat_d  = sat_add ? (sum_ext[WORD_LEN] ? MIN_VAL : MAX_VAL) : sum_ext[WORD_LEN-1:0];
        diff_ext = {y1_q[WORD_LEN-1], y1_q} - {y_hat_d[WORD_LEN-1], y_hat_d};
        sat_sub  = diff_ext[WORD_LEN] ^ diff_ext[WORD_LEN-1];
        err_d    = sat_sub ? (diff_ext[WORD_LEN] ? MIN_VAL : MAX_VAL) : diff_ext[WORD_LEN-1:0];
`else
        y_hat_d  = b0 + scaled_w;
        err_d    = y1_q - y_hat_d;
`endif
    end

    // Pipeline registers, frozen while the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            prod_q  <= '0;
            y1_q    <= '0;
            idx1_q  <= '0;
            v2_q    <= 1'b0;
            y_hat_q <= '0;
            err_q   <= '0;
            idx2_q  <= '0;
        end else if (en) begin
            v1_q <= in_fire;
            if (in_fire) begin
                prod_q <= prod_d;
                y1_q   <= y;
                idx1_q <= idx_in;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                y_hat_q <= y_hat_d;
                err_q   <= err_d;
                idx2_q  <= idx1_q;
            end
        end
    end

`ifdef REGRESSION_ERR_SAT_EN
    // Sticky saturation record for the current run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (clr_sat) begin
            sat_q <= 1'b0;
        end else if (en && v1_q && (sat_add || sat_sub)) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`endif

    assign out_valid = v2_q;
    assign y_hat     = y_hat_q;
    assign err       = err_q;
    assign idx       = idx2_q;

endmodule

// File: rtl/regression_error_calc.sv
// Regression residual calculator: latches b0/b1 on start, streams SAMPLE_COUNT
// (x, y) pairs through the prediction pipe and reports y_hat / err per sample.
// Build option REGRESSION_ERR_SAT_EN adds saturation and the sat_flag port.
module regression_error_calc
    import regression_error_calc_pkg::*;
#(
    parameter int unsigned WORD_LEN     = WORD_LEN_DEF,
    parameter int unsigned FRAC_BITS    = FRAC_BITS_DEF,
    parameter int unsigned SAMPLE_COUNT = SAMPLE_COUNT_DEF,
    parameter int unsigned IDX_LEN      = IDX_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WORD_LEN-1:0] b0,
    input  logic [WORD_LEN-1:0] b1,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_LEN-1:0] x_in,
    input  logic [WORD_LEN-1:0] y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_LEN-1:0] y_hat,
    output logic [WORD_LEN-1:0] err,
    output logic [IDX_LEN-1:0]  idx,
`ifdef REGRESSION_ERR_SAT_EN
    output logic                sat_flag,
`endif
    output logic                busy,
    output logic                done
);

    localparam logic [IDX_LEN-1:0] COUNT    = IDX_LEN'(SAMPLE_COUNT);
    localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(SAMPLE_COUNT - 1);

    logic [1:0]          state_q, state_d;
    logic [WORD_LEN-1:0] b0_q, b0_d, b1_q, b1_d;
    logic [IDX_LEN-1:0]  in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic                stall, in_fire, out_fire, accept_start;

    assign stall        = out_valid & ~out_ready;
    assign in_ready     = (state_q == ST_RUN) & (in_cnt_q < COUNT) & ~stall;
    assign in_fire      = in_valid & in_ready;
    assign out_fire     = out_valid & out_ready;
    assign accept_start = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign busy         = (state_q == ST_RUN) | (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);

    // Run control: coefficient latch, transfer counters and state sequencing
    always_comb begin
        state_d   = state_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        in_cnt_d  = in_cnt_q + IDX_LEN'(in_fire);
        out_cnt_d = out_cnt_q + IDX_LEN'(out_fire);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    b0_d      = b0;
                    b1_d      = b1;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_fire && (in_cnt_q == LAST_IDX)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Last output can only leave after the last input, so it lands here
                if (out_fire && (out_cnt_q == LAST_IDX)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            b0_q      <= '0;
            b1_q      <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    regression_predict_pipe #(
        .WORD_LEN  (WORD_LEN),
        .FRAC_BITS (FRAC_BITS),
        .IDX_LEN   (IDX_LEN)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (~stall),
        .in_fire   (in_fire),
        .b0        (b0_q),
        .b1        (b1_q),
        .x         (x_in),
        .y         (y_in),
        .idx_in    (in_cnt_q),
`ifdef REGRESSION_ERR_SAT_EN
        .clr_sat   (accept_start),
        .sat_flag  (sat_flag),
`endif
        .out_valid (out_valid),
        .y_hat     (y_hat),
        .err       (err),
        .idx       (idx)
    );

endmodule

// File: tb/tb_regression_error_calc.sv
// Bench for regression_error_calc: table-driven single-sample runs on a
// SAMPLE_COUNT=1 instance, scoreboarded full runs on the default instance.
module tb_regression_error_calc;

    localparam int N = 150;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Main instance (SAMPLE_COUNT = 150)
    logic        start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [19:0] b0, b1, x_in, y_in, y_hat, err;
    logic [7:0]  idx;
    // Single-sample instance
    logic        start_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s, done_s;
    logic [19:0] b0_s, b1_s, x_s, y_s, y_hat_s, err_s;
    logic [7:0]  idx_s;
`ifdef REGRESSION_ERR_SAT_EN
    logic        sat_flag, sat_flag_s;
`endif

    regression_error_calc dut (
        .clk(clk), .rst(rst), .start(start), .b0(b0), .b1(b1),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready), .y_hat(y_hat), .err(err), .idx(idx),
`ifdef REGRESSION_ERR_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy), .done(done)
    );

    regression_error_calc #(.SAMPLE_COUNT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s), .b0(b0_s), .b1(b1_s),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .x_in(x_s), .y_in(y_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .y_hat(y_hat_s), .err(err_s),
        .idx(idx_s),
`ifdef REGRESSION_ERR_SAT_EN
        .sat_flag(sat_flag_s),
`endif
        .busy(busy_s), .done(done_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: Q(WORD_LEN-FRAC).FRAC arithmetic on wide integers
    function automatic void model(input logic [19:0] b0v, input logic [19:0] b1v,
                                  input logic [19:0] xv, input logic [19:0] yv,
                                  output logic [19:0] yh, output logic [19:0] er);
        longint p, s, d;
        logic signed [19:0] sc, yhs;
        p  = longint'($signed(b1v)) * longint'($signed(xv));
        p  = p >>> 10;
        sc = p[19:0];
        s  = longint'($signed(b0v)) + longint'(sc);
`ifdef REGRESSION_ERR_SAT_EN
        if (s > 524287) s = 524287;
        if (s < -524288) s = -524288;
`endif
        yh  = s[19:0];
        yhs = yh;
        d   = longint'($signed(yv)) - longint'(yhs);
`ifdef REGRESSION_ERR_SAT_EN
        if (d > 524287) d = 524287;
        if (d < -524288) d = -524288;
`endif
        er = d[19:0];
    endfunction

    typedef struct {
        logic [19:0] yh;
        logic [19:0] er;
        logic [7:0]  idx;
    } exp_t;
    exp_t sbq[$];

    logic [19:0] cur_b0, cur_b1;
    int          exp_idx, out_seen;

    // Scoreboard monitor plus stall-stability checks on the main instance
    initial begin
        logic        prev_stall;
        logic [19:0] prev_yh, prev_er;
        logic [7:0]  prev_idx;
        exp_t        e;
        prev_stall = 1'b0;
        prev_yh = '0; prev_er = '0; prev_idx = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_yhat", y_hat, prev_yh);
                    check("hold_err", err, prev_er);
                    check("hold_idx", idx, prev_idx);
                end
                if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
                prev_stall = out_valid && !out_ready;
                prev_yh = y_hat; prev_er = err; prev_idx = idx;
                if (in_valid && in_ready) begin
                    model(cur_b0, cur_b1, x_in, y_in, e.yh, e.er);
                    e.idx = 8'(exp_idx);
                    sbq.push_back(e);
                    exp_idx++;
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_output: got idx %0d, expected none", idx);
                    end else begin
                        e = sbq.pop_front();
                        check("out_yhat", y_hat, e.yh);
                        check("out_err", err, e.er);
                        check("out_idx", idx, e.idx);
                    end
                    out_seen++;
                end
            end
        end
    end

    typedef struct {
        logic [19:0] b0, b1, x, y, yh, er;
        logic        sat;
    } vec_t;
    vec_t vecs[5];

    task automatic run_single(input vec_t v);
        @(posedge clk); #1;
        b0_s = v.b0; b1_s = v.b1; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0; in_valid_s = 1'b1; x_s = v.x; y_s = v.y;
        @(negedge clk);
        check("s_in_ready", in_ready_s, 1);
        check("s_busy", busy_s, 1);
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        @(negedge clk);
        check("s_lat1_no_valid", out_valid_s, 0);
        check("s_in_ready_drain", in_ready_s, 0);
        @(negedge clk);
        check("s_lat2_valid", out_valid_s, 1);
        check("s_yhat", y_hat_s, v.yh);
        check("s_err", err_s, v.er);
        check("s_idx", idx_s, 0);
        check("s_done_early", done_s, 0);
        @(negedge clk);
        check("s_done", done_s, 1);
        check("s_busy_end", busy_s, 0);
        check("s_valid_end", out_valid_s, 0);
`ifdef REGRESSION_ERR_SAT_EN
        check("s_sat_flag", sat_flag_s, v.sat);
`endif
    endtask

    task automatic run_main(input logic [19:0] b0v, input logic [19:0] b1v,
                            input int stall_at, input int abort_at);
        int  n, cyc, stall_left;
        bit  stalled, fire, pf;
        @(posedge clk); #1;
        b0 = b0v; b1 = b1v; start = 1'b1;
        cur_b0 = b0v; cur_b1 = b1v; exp_idx = 0; out_seen = 0; sbq.delete();
        @(posedge clk); #1;
        start = 1'b0;
        check("m_busy_start", busy, 1);
        check("m_done_cleared", done, 0);
        n = 0; cyc = 0; stall_left = 0; stalled = 0;
        in_valid = 1'b1; x_in = 20'($urandom); y_in = 20'($urandom);
        while (n < N) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            cyc++;
            if (cyc > 2000) begin
                checks++; errors++;
                $display("FAIL input_timeout: got %0d accepts, expected %0d", n, N);
                break;
            end
            @(posedge clk); #1;
            if (fire) begin
                n++;
                x_in = 20'($urandom); y_in = 20'($urandom);
            end
            if (stall_at >= 0 && n == stall_at && !stalled) begin
                out_ready = 1'b0; stall_left = 5; stalled = 1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end
            if (abort_at >= 0 && n == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("abort_out_valid", out_valid, 0);
                check("abort_y_hat", y_hat, 0);
                check("abort_err", err, 0);
                check("abort_idx", idx, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_in_ready", in_ready, 0);
                in_valid = 1'b0; out_ready = 1'b1;
                sbq.delete();
                rst = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("m_in_ready_after_last", in_ready, 0);
        pf = 0;
        for (int t = 0; t < 600; t++) begin
            if (done) break;
            pf = out_valid && out_ready;
            @(negedge clk);
        end
        check("m_done", done, 1);
        check("m_done_after_last_out", pf, 1);
        check("m_busy_end", busy, 0);
        check("m_in_ready_end", in_ready, 0);
        check("m_out_count", out_seen, N);
        check("m_sb_empty", sbq.size(), 0);
    endtask

    initial begin
        vecs[0] = '{20'h00400, 20'h00800, 20'h00C00, 20'h01E00, 20'h01C00, 20'h00200, 1'b0};
        vecs[1] = '{20'h00000, 20'hFFC00, 20'h00800, 20'h00000, 20'hFF800, 20'h00800, 1'b0};
`ifdef REGRESSION_ERR_SAT_EN
        vecs[2] = '{20'h7FC00, 20'h00400, 20'h00800, 20'h00000, 20'h7FFFF, 20'h80001, 1'b1};
`else
        vecs[2] = '{20'h7FC00, 20'h00400, 20'h00800, 20'h00000, 20'h80400, 20'h7FC00, 1'b0};
`endif
        vecs[3] = '{20'hFFE00, 20'h00200, 20'h01000, 20'h00000, 20'h00600, 20'hFFA00, 1'b0};
        vecs[4] = '{20'h00400, 20'h00400, 20'hFFC00, 20'h00100, 20'h00000, 20'h00100, 1'b0};

        rst = 1'b1;
        start = 0; b0 = 0; b1 = 0; in_valid = 0; x_in = 0; y_in = 0; out_ready = 1;
        start_s = 0; b0_s = 0; b1_s = 0; in_valid_s = 0; x_s = 0; y_s = 0; out_ready_s = 1;
        cur_b0 = 0; cur_b1 = 0; exp_idx = 0; out_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y_hat", y_hat, 0);
        check("rst_err", err, 0);
        check("rst_idx", idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_single(vecs[i]);

        run_main(20'h00200, 20'h00600, -1, -1);   // back-to-back, no stall
        run_main(20'hFF000, 20'hFFA00, 40, -1);   // 5-cycle stall mid-stream
        run_main(20'h00100, 20'h00400, -1, 10);   // reset after 10 pairs
        run_main(20'h00300, 20'h00C00, 7, -1);    // restart: idx from 0 again

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regression_error_calc.md
Name: regression_error_calc

Overview:
- Consumer-side companion to the linear-regression coefficient datapath.
- Latches the fitted b0 and b1, then re-streams the same SAMPLE_COUNT (x, y) pairs.
- For each pair it computes the prediction y_hat = b0 + b1*x and the residual err = y - y_hat, and emits both on a valid/ready output stream.
- Asserts done after the last residual has been accepted; feeds the accuracy check stage.

Parameters:
- WORD_LEN, 20: data width of x, y, b0, b1, y_hat and err.
- FRAC_BITS, 10: fractional bits of the two's-complement fixed-point format.
- SAMPLE_COUNT, 150: number of pairs processed per run.
- IDX_LEN, 8: width of the sample index; must satisfy 2^IDX_LEN > SAMPLE_COUNT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; latches b0 and b1 and begins a run.
- b0  input  WORD_LEN  intercept, sampled only on start.
- b1  input  WORD_LEN  slope, sampled only on start.
- in_valid  input  1  x_in and y_in are valid.
- in_ready  output  1  the block accepts a pair this cycle.
- x_in  input  WORD_LEN  sample x.
- y_in  input  WORD_LEN  sample y.
- out_valid  output  1  y_hat, err and idx are valid.
- out_ready  input  1  downstream accepts the output.
- y_hat  output  WORD_LEN  predicted y.
- err  output  WORD_LEN  residual y - y_hat.
- idx  output  IDX_LEN  index of the sample, 0 to SAMPLE_COUNT-1.
- busy  output  1  a run is in progress.
- done  output  1  run complete; held until the next start.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs, internal registers and counters are 0. Reset mid-run aborts the run immediately, and no partial done is produced.
- States:
  - IDLE: on start, latch b0/b1, clear counters, go to RUN.
  - RUN: accept pairs. After SAMPLE_COUNT pairs have been accepted, go to DRAIN.
  - DRAIN: wait until the pipeline is empty and the last output has been accepted, then go to DONE.
  - DONE: done=1. On start, latch new coefficients, clear done, go to RUN.
- busy=1 in RUN and DRAIN only.
- start is ignored in RUN and DRAIN.
- Handshake: a transfer happens on a cycle with valid & ready on the same interface.
- in_ready = (state==RUN) & (in_cnt < SAMPLE_COUNT) & ~stall.
- stall = out_valid & ~out_ready.
- out_valid, y_hat, err and idx stay stable while stalled.
- Pipeline, 2 registered stages, advancing only when ~stall:
  - S1 registers prod = b1*x as a full 2*WORD_LEN signed product, plus y and the index.
  - S2 computes y_hat = b0 + prod[WORD_LEN+FRAC_BITS-1:FRAC_BITS] and err = y - y_hat. Both wrap modulo 2^WORD_LEN.
- Latency: input transfer to out_valid is 2 cycles with out_ready held high. Throughput is 1 pair/cycle.
- Counters:
  - in_cnt counts input transfers.
  - out_cnt counts output transfers.
  - idx equals the input order; it never wraps within a run.
- Boundary conditions:
  - in_valid while in_ready=0: the pair is not consumed.
  - A stall at the final sample holds DRAIN.
  - done rises the cycle after the SAMPLE_COUNT-th output transfer.
  - out_ready low forever: the block holds with no data loss.

Optional Feature:
- Macro: REGRESSION_ERR_SAT_EN.
- Defined: the y_hat and err add/subtract saturate to the signed WORD_LEN limits (0x7FFFF / 0x80000) on overflow, and a sticky output sat_flag (1 bit, cleared on start/reset) records any saturation in the run.
- Undefined: results wrap modulo 2^WORD_LEN and the sat_flag port is absent.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the WORD_LEN, FRAC_BITS and SAMPLE_COUNT defaults;
  - a fixed-point multiply-and-rescale function.
- One natural sub-module: regression_predict_pipe. It holds the 2-stage multiply/add/sub pipeline with enable-based stall; the FSM, counters and handshake stay in the top.

Test Plan:
- Single sample, SAMPLE_COUNT=1: b0=0x00400 (1.0), b1=0x00800 (2.0), x=0x00C00 (3.0), y=0x01E00 (7.5). Expect y_hat=0x01C00, err=0x00200, idx=0, out_valid exactly 2 cycles after the input transfer, done 1 cycle after the output is accepted.
- Full run, 150 pairs streamed back-to-back, out_ready=1: expect 150 outputs, idx 0 to 149 in order, in_ready=0 after the 150th accept, done=1 and busy=0 at the end.
- Backpressure: out_ready low for 5 cycles mid-stream. Expect in_ready=0 while stalled, outputs held stable, no pair dropped or duplicated, correct err sequence afterwards.
- Negative values: b1=0xFFC00 (-1.0), x=0x00800 (2.0), b0=0, y=0. Expect y_hat=0xFF800 and err=0x00800.
- Asynchronous reset asserted during RUN after 10 pairs: expect all outputs 0 and IDLE immediately. A new start then restarts idx at 0.
- With REGRESSION_ERR_SAT_EN: b0=0x7FC00, b1=0x00400, x=0x00800, y=0. Expect y_hat=0x7FFFF, err=0x80001, sat_flag=1. Without the macro, y_hat wraps to 0x80400.
